// File: rtl/fifo_drain_fsm.sv
// Read-side drain controller for the 8-entry FIFO: waits for a start level,
// pops down to a stop level, and checks every popped word against a pattern.
module fifo_drain_fsm #(
  parameter int                 DATA_W    = 8,
  parameter int                 WORDS_W   = 4,
  parameter int                 START_LVL = 3,
  parameter int                 STOP_LVL  = 0,
  parameter logic [DATA_W-1:0]  EXP_DATA  = 8'hAA,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORDS_W-1:0] fifo_words,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               rd_en,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_valid,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               err_flag
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam logic [WORDS_W-1:0] START_TH = WORDS_W'(START_LVL);
  localparam logic [WORDS_W-1:0] STOP_TH  = WORDS_W'(STOP_LVL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + 1'b1;
  endfunction

  logic [0:0]         state;
  logic               rd_pend;
  logic [WORDS_W-1:0] avail;
  logic               mismatch;

  // Occupancy once the pop being sampled this edge has been taken.
  assign avail    = fifo_words - {{(WORDS_W-1){1'b0}}, rd_en};
  assign mismatch = (fifo_q != EXP_DATA);

  // Stage 0: pop control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_words >= START_TH) begin
            rd_en <= 1'b1;
            state <= DRAIN;
          end else begin
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (avail > STOP_TH) begin
            rd_en <= 1'b1;
          end else begin
            rd_en <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          rd_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage 1: capture popped word one cycle after the pop, count and check it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend    <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
      rd_count   <= '0;
      err_count  <= '0;
      err_flag   <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_pend) begin
        data_out   <= fifo_q;
        data_valid <= 1'b1;
        rd_count   <= wrap_inc(rd_count);
        if (mismatch) begin
          err_count <= sat_inc(err_count);
          err_flag  <= 1'b1;
        end
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Directed bench for fifo_drain_fsm: two instances (stop level 0 and 2) each
// fed by a small behavioural FIFO model.
module tb_fifo_drain_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Instance A: default parameters
  logic [3:0]  words_a;
  logic [7:0]  q_a = 8'h5A;
  logic        rd_en_a, dv_a, err_flag_a;
  logic [7:0]  dout_a;
  logic [15:0] rd_count_a, err_count_a;

  // Instance B: STOP_LVL=2, narrow counters to reach wrap and saturation
  logic [3:0]  words_b;
  logic [7:0]  q_b = 8'h5A;
  logic        rd_en_b, dv_b, err_flag_b;
  logic [7:0]  dout_b;
  logic [1:0]  rd_count_b, err_count_b;

  fifo_drain_fsm dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_words(words_a), .fifo_q(q_a),
    .rd_en(rd_en_a), .data_out(dout_a), .data_valid(dv_a),
    .rd_count(rd_count_a), .err_count(err_count_a), .err_flag(err_flag_a)
  );

  fifo_drain_fsm #(.STOP_LVL(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_words(words_b), .fifo_q(q_b),
    .rd_en(rd_en_b), .data_out(dout_b), .data_valid(dv_b),
    .rd_count(rd_count_b), .err_count(err_count_b), .err_flag(err_flag_b)
  );

  // FIFO models: one push per cycle, pop on rd_en, garbage on q when idle
  logic       push_a = 1'b0, flush_a = 1'b0, push_b = 1'b0, flush_b = 1'b0;
  logic [7:0] pd_a = 8'h00, pd_b = 8'h00;
  logic [7:0] mem_a [0:15];
  logic [7:0] mem_b [0:15];
  int rp_a = 0, wp_a = 0, cnt_a = 0, pops_a = 0, udf_a = 0;
  int rp_b = 0, wp_b = 0, cnt_b = 0, pops_b = 0, udf_b = 0;

  assign words_a = 4'(cnt_a);
  assign words_b = 4'(cnt_b);

  always @(posedge clk) begin
    if (flush_a) begin
      rp_a <= 0; wp_a <= 0; cnt_a <= 0; q_a <= 8'h5A;
    end else begin
      if (rd_en_a && cnt_a == 0) udf_a <= udf_a + 1;
      if (rd_en_a && cnt_a > 0) begin
        q_a <= mem_a[rp_a]; rp_a <= (rp_a + 1) % 16; pops_a <= pops_a + 1;
      end else begin
        q_a <= 8'h5A;
      end
      if (push_a) begin
        mem_a[wp_a] <= pd_a; wp_a <= (wp_a + 1) % 16;
      end
      cnt_a <= cnt_a + (push_a ? 1 : 0) - ((rd_en_a && cnt_a > 0) ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    if (flush_b) begin
      rp_b <= 0; wp_b <= 0; cnt_b <= 0; q_b <= 8'h5A;
    end else begin
      if (rd_en_b && cnt_b == 0) udf_b <= udf_b + 1;
      if (rd_en_b && cnt_b > 0) begin
        q_b <= mem_b[rp_b]; rp_b <= (rp_b + 1) % 16; pops_b <= pops_b + 1;
      end else begin
        q_b <= 8'h5A;
      end
      if (push_b) begin
        mem_b[wp_b] <= pd_b; wp_b <= (wp_b + 1) % 16;
      end
      cnt_b <= cnt_b + (push_b ? 1 : 0) - ((rd_en_b && cnt_b > 0) ? 1 : 0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic push_word_a(input logic [7:0] v);
    push_a = 1'b1; pd_a = v;
    @(negedge clk);
    push_a = 1'b0;
  endtask

  task automatic push_word_b(input logic [7:0] v);
    push_b = 1'b1; pd_b = v;
    @(negedge clk);
    push_b = 1'b0;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_a = 1'b1; flush_b = 1'b1;
    @(negedge clk);
    flush_a = 1'b0; flush_b = 1'b0;
  endtask

  task automatic test_reset();
    enter_reset();
    for (int i = 0; i < 8; i++) push_word_a(8'hAA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rd_en_a, dv_a, err_flag_a} !== 3'b000 || rd_count_a !== 16'd0 || err_count_a !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: rd_en=%b dv=%b flag=%b rd_count=%0d err_count=%0d expected all 0",
                 i, rd_en_a, dv_a, err_flag_a, rd_count_a, err_count_a);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) @(negedge clk);
    n_checks++;
    if (rd_count_a !== 16'd8) begin
      n_fail++; $display("FAIL full_drain_rd_count: got %0d expected 8", rd_count_a);
    end
    n_checks++;
    if (cnt_a !== 0 || udf_a !== 0) begin
      n_fail++; $display("FAIL full_drain_fifo: level %0d underflows %0d expected 0 and 0", cnt_a, udf_a);
    end
  endtask

  task automatic test_drain5();
    int p0;
    logic exp_rd, exp_dv;
    enter_reset();
    for (int i = 0; i < 5; i++) push_word_a(8'hAA);
    p0 = pops_a;
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_rd = (i >= 1 && i <= 5);
      exp_dv = (i >= 3 && i <= 7);
      n_checks++;
      if (rd_en_a !== exp_rd) begin
        n_fail++; $display("FAIL drain5_rd_en[%0d]: got %b expected %b", i, rd_en_a, exp_rd);
      end
      n_checks++;
      if (dv_a !== exp_dv) begin
        n_fail++; $display("FAIL drain5_valid[%0d]: got %b expected %b", i, dv_a, exp_dv);
      end
      if (exp_dv) begin
        n_checks++;
        if (dout_a !== 8'hAA) begin
          n_fail++; $display("FAIL drain5_data[%0d]: got %h expected aa", i, dout_a);
        end
      end
    end
    n_checks++;
    if (rd_count_a !== 16'd5 || err_count_a !== 16'd0 || err_flag_a !== 1'b0) begin
      n_fail++; $display("FAIL drain5_stats: rd_count=%0d err_count=%0d flag=%b expected 5 0 0",
                         rd_count_a, err_count_a, err_flag_a);
    end
    n_checks++;
    if (pops_a - p0 !== 5 || cnt_a !== 0 || udf_a !== 0) begin
      n_fail++; $display("FAIL drain5_fifo: pops=%0d level=%0d underflows=%0d expected 5 0 0",
                         pops_a - p0, cnt_a, udf_a);
    end
  endtask

  task automatic test_below_start();
    int seen_rd;
    enter_reset();
    push_word_a(8'hAA); push_word_a(8'hAA);
    rst_n = 1'b1;
    seen_rd = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en_a) seen_rd++;
    end
    n_checks++;
    if (seen_rd !== 0) begin
      n_fail++; $display("FAIL below_start_rd_en: high for %0d cycles expected 0", seen_rd);
    end
    n_checks++;
    if (rd_count_a !== 16'd0 || cnt_a !== 2) begin
      n_fail++; $display("FAIL below_start_state: rd_count=%0d level=%0d expected 0 2", rd_count_a, cnt_a);
    end
  endtask

  task automatic test_errors();
    enter_reset();
    push_word_a(8'hAA); push_word_a(8'hAA); push_word_a(8'h55); push_word_a(8'hAA);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    n_checks++;
    if (rd_count_a !== 16'd4 || err_count_a !== 16'd1 || err_flag_a !== 1'b1) begin
      n_fail++; $display("FAIL err_first: rd_count=%0d err_count=%0d flag=%b expected 4 1 1",
                         rd_count_a, err_count_a, err_flag_a);
    end
    n_checks++;
    if (dout_a !== 8'hAA) begin
      n_fail++; $display("FAIL err_last_data: got %h expected aa", dout_a);
    end
    for (int i = 0; i < 4; i++) push_word_a(8'hAA);
    for (int i = 0; i < 12; i++) @(negedge clk);
    n_checks++;
    if (rd_count_a !== 16'd8 || err_count_a !== 16'd1 || err_flag_a !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: rd_count=%0d err_count=%0d flag=%b expected 8 1 1",
                         rd_count_a, err_count_a, err_flag_a);
    end
    n_checks++;
    if (cnt_a !== 0 || udf_a !== 0) begin
      n_fail++; $display("FAIL err_fifo: level=%0d underflows=%0d expected 0 0", cnt_a, udf_a);
    end
  endtask

  task automatic test_stop_lvl();
    int p0;
    enter_reset();
    for (int i = 0; i < 6; i++) push_word_b(8'h55);
    p0 = pops_b;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    n_checks++;
    if (pops_b - p0 !== 4 || cnt_b !== 2 || udf_b !== 0) begin
      n_fail++; $display("FAIL stop_lvl_pops: pops=%0d level=%0d underflows=%0d expected 4 2 0",
                         pops_b - p0, cnt_b, udf_b);
    end
    n_checks++;
    if (rd_en_b !== 1'b0 || dv_b !== 1'b0) begin
      n_fail++; $display("FAIL stop_lvl_idle: rd_en=%b dv=%b expected 0 0", rd_en_b, dv_b);
    end
    n_checks++;
    if (rd_count_b !== 2'd0) begin
      n_fail++; $display("FAIL stop_lvl_rd_wrap: got %0d expected 0", rd_count_b);
    end
    n_checks++;
    if (err_count_b !== 2'd3 || err_flag_b !== 1'b1) begin
      n_fail++; $display("FAIL stop_lvl_err_sat: err_count=%0d flag=%b expected 3 1", err_count_b, err_flag_b);
    end
    n_checks++;
    if (dout_b !== 8'h55) begin
      n_fail++; $display("FAIL stop_lvl_data: got %h expected 55", dout_b);
    end
  endtask

  task automatic test_reset_mid_drain();
    enter_reset();
    for (int i = 0; i < 6; i++) push_word_a(8'hAA);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_en_a !== 1'b0 || dv_a !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: rd_en=%b dv=%b expected 0 0", rd_en_a, dv_a);
    end
    n_checks++;
    if (rd_count_a !== 16'd0 || err_count_a !== 16'd0 || dout_a !== 8'h00) begin
      n_fail++; $display("FAIL midrst_counters: rd_count=%0d err_count=%0d data=%h expected 0 0 00",
                         rd_count_a, err_count_a, dout_a);
    end
    n_checks++;
    if (cnt_a !== 4) begin
      n_fail++; $display("FAIL midrst_level: got %0d expected 4", cnt_a);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dv_a !== 1'b0 || rd_en_a !== 1'b1) begin
      n_fail++; $display("FAIL midrst_restart: dv=%b rd_en=%b expected 0 1", dv_a, rd_en_a);
    end
    for (int i = 0; i < 10; i++) @(negedge clk);
    n_checks++;
    if (rd_count_a !== 16'd4 || cnt_a !== 0 || udf_a !== 0) begin
      n_fail++; $display("FAIL midrst_finish: rd_count=%0d level=%0d underflows=%0d expected 4 0 0",
                         rd_count_a, cnt_a, udf_a);
    end
  endtask

  initial begin
    test_reset();
    test_drain5();
    test_below_start();
    test_errors();
    test_stop_lvl();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
